// File: rtl/mul_wb_queue_if.sv
// Producer/consumer bundle for the multiply writeback queue.
// The master side drives results in and grants writeback; the slave side is the queue.
interface mul_wb_queue_if #(
    parameter int unsigned WORD_SIZE       = 32,
    parameter int unsigned INSTR_TYPE_SZ   = 4,
    parameter int unsigned ROB_ENTRY_WIDTH = 6
);
    logic                       in_valid;
    logic [INSTR_TYPE_SZ-1:0]   in_instruction_type;
    logic [WORD_SIZE-1:0]       in_pc;
    logic [WORD_SIZE-1:0]       in_result;
    logic [ROB_ENTRY_WIDTH-1:0] in_rob_id;
    logic                       wb_ready;
    logic                       wb_valid;
    logic [INSTR_TYPE_SZ-1:0]   wb_instruction_type;
    logic [WORD_SIZE-1:0]       wb_pc;
    logic [WORD_SIZE-1:0]       wb_result;
    logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id;

    modport master (
        output in_valid, in_instruction_type, in_pc, in_result, in_rob_id, wb_ready,
        input  wb_valid, wb_instruction_type, wb_pc, wb_result, wb_rob_id
    );

    modport slave (
        input  in_valid, in_instruction_type, in_pc, in_result, in_rob_id, wb_ready,
        output wb_valid, wb_instruction_type, wb_pc, wb_result, wb_rob_id
    );
endinterface

// File: rtl/mul_wb_queue.sv
// Writeback queue behind the multiply pipe: in-order circular buffer with an early
// issue stall that leaves room for every multiply still in flight.
module mul_wb_queue #(
    parameter int unsigned WORD_SIZE       = 32,
    parameter int unsigned INSTR_TYPE_SZ   = 4,
    parameter int unsigned ROB_ENTRY_WIDTH = 6,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned STALL_MARGIN    = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    mul_wb_queue_if.slave              bus,
    output logic                       stall_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow_err
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullLvl  = CW'(DEPTH);
    localparam logic [CW-1:0] StallLvl = CW'(DEPTH - STALL_MARGIN);

    logic [INSTR_TYPE_SZ-1:0]   mem_type   [DEPTH];
    logic [WORD_SIZE-1:0]       mem_pc     [DEPTH];
    logic [WORD_SIZE-1:0]       mem_result [DEPTH];
    logic [ROB_ENTRY_WIDTH-1:0] mem_rob_id [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop;

    // A pop in the same cycle frees the slot, so a full queue still accepts.
    always_comb begin
        pop        = (count_q != '0) && bus.wb_ready;
        push       = bus.in_valid && ((count_q != FullLvl) || pop);
        rd_ptr_d   = pop  ? PW'(rd_ptr_q + 1'b1) : rd_ptr_q;
        wr_ptr_d   = push ? PW'(wr_ptr_q + 1'b1) : wr_ptr_q;
        overflow_d = overflow_q || (bus.in_valid && !push);
        count_d    = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_type[i]   <= '0;
                mem_pc[i]     <= '0;
                mem_result[i] <= '0;
                mem_rob_id[i] <= '0;
            end
        end else if (push) begin
            mem_type[wr_ptr_q]   <= bus.in_instruction_type;
            mem_pc[wr_ptr_q]     <= bus.in_pc;
            mem_result[wr_ptr_q] <= bus.in_result;
            mem_rob_id[wr_ptr_q] <= bus.in_rob_id;
        end
    end

    always_comb begin
        bus.wb_valid            = (count_q != '0);
        bus.wb_instruction_type = mem_type[rd_ptr_q];
        bus.wb_pc               = mem_pc[rd_ptr_q];
        bus.wb_result           = mem_result[rd_ptr_q];
        bus.wb_rob_id           = mem_rob_id[rd_ptr_q];
        stall_out               = (count_q >= StallLvl);
        count                   = count_q;
        overflow_err            = overflow_q;
    end
endmodule
